// File: rtl/pipeline_hazard_controller.sv
// Stall/flush/next-PC sequencer for the 5-stage MIPS pipeline (IF, ID, EX, ME, WB).
// Optional stall/flush performance counters are built when HAZARD_PERF_COUNTERS_EN is defined.
module pipeline_hazard_controller #(
  parameter int CNT_WIDTH   = 16,
  parameter int JR_WAIT_MAX = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rt,
  input  logic [1:0] id_jump,
  input  logic       ex_mem_read,
  input  logic       ex_reg_write,
  input  logic [4:0] ex_write_reg,
  input  logic       me_reg_write,
  input  logic [4:0] me_write_reg,
  input  logic       me_pc_src,
  input  logic       ext_stall_req,
  output logic       pc_write,
  output logic       if_id_write,
  output logic       if_id_flush,
  output logic       id_ex_flush,
  output logic       ex_me_flush,
  output logic [1:0] pc_sel,
  output logic [1:0] ctrl_state,
  output logic       jr_fault
`ifdef HAZARD_PERF_COUNTERS_EN
  ,
  output logic [CNT_WIDTH-1:0] stall_count,
  output logic [CNT_WIDTH-1:0] flush_count
`endif
);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    LU_STALL = 2'b01,
    JR_WAIT  = 2'b10,
    EXT_WAIT = 2'b11
  } state_e;

  localparam logic [1:0] SEL_PC4    = 2'b00;
  localparam logic [1:0] SEL_BRANCH = 2'b01;
  localparam logic [1:0] SEL_JUMP   = 2'b10;
  localparam logic [1:0] SEL_JR     = 2'b11;

  localparam logic [1:0] JMP_J  = 2'b01;
  localparam logic [1:0] JMP_JR = 2'b10;

  // Wait counter only needs to reach one past the limit; it saturates there.
  localparam int              WAIT_W   = $clog2(JR_WAIT_MAX + 2);
  localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(JR_WAIT_MAX);
  localparam logic [WAIT_W-1:0] WAIT_TOP = WAIT_W'(JR_WAIT_MAX + 1);

  state_e             state_q, state_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic               fault_q, fault_d;

  // Hazard decode; register $0 is hard-wired zero and never creates a dependency.
  logic rs_nz, rt_nz;
  logic ex_hits_rs, ex_hits_rt, me_hits_rs;
  logic load_use, jr_hazard, is_j, is_jr;

  assign rs_nz      = (id_rs != 5'd0);
  assign rt_nz      = (id_rt != 5'd0);
  assign ex_hits_rs = rs_nz && (ex_write_reg == id_rs);
  assign ex_hits_rt = rt_nz && (ex_write_reg == id_rt);
  assign me_hits_rs = rs_nz && (me_write_reg == id_rs);

  assign is_j      = (id_jump == JMP_J);
  assign is_jr     = (id_jump == JMP_JR);
  assign load_use  = ex_mem_read && (ex_hits_rs || (id_uses_rt && ex_hits_rt));
  assign jr_hazard = is_jr && ((ex_reg_write && ex_hits_rs) || (me_reg_write && me_hits_rs));

  always_comb begin
    state_d     = RUN;
    wait_d      = '0;
    pc_write    = 1'b1;
    if_id_write = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    ex_me_flush = 1'b0;
    pc_sel      = SEL_PC4;
    if (!reset) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      ex_me_flush = 1'b1;
    end else if (me_pc_src) begin
      // A taken branch squashes everything younger and aborts any stall.
      pc_sel      = SEL_BRANCH;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
      ex_me_flush = 1'b1;
    end else if (ext_stall_req) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      state_d     = EXT_WAIT;
    end else if (load_use) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      id_ex_flush = 1'b1;
      state_d     = LU_STALL;
    end else if (jr_hazard) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      id_ex_flush = 1'b1;
      state_d     = JR_WAIT;
      wait_d      = (wait_q == WAIT_TOP) ? wait_q : wait_q + 1'b1;
    end else if (is_j) begin
      pc_sel      = SEL_JUMP;
      if_id_flush = 1'b1;
    end else if (is_jr) begin
      pc_sel      = SEL_JR;
      if_id_flush = 1'b1;
    end
  end

  assign fault_d = fault_q || (wait_d > WAIT_LIM);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= RUN;
      wait_q  <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      fault_q <= fault_d;
    end
  end

  assign ctrl_state = state_q;
  assign jr_fault   = fault_q;

`ifdef HAZARD_PERF_COUNTERS_EN
  logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_WIDTH-1:0] flush_cnt_q, flush_cnt_d;
  logic                 any_flush;

  assign any_flush = if_id_flush || id_ex_flush || ex_me_flush;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!pc_write && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
    if (any_flush && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_count = stall_cnt_q;
  assign flush_count = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Randomized + directed bench for pipeline_hazard_controller with a rule-level reference model.
module tb_pipeline_hazard_controller;

  localparam int CNT_WIDTH   = 16;
  localparam int JR_WAIT_MAX = 3;
  localparam int CNT_MAX     = (1 << CNT_WIDTH) - 1;
`ifdef HAZARD_PERF_COUNTERS_EN
  localparam int W = 10 + 2 * CNT_WIDTH;
`else
  localparam int W = 10;
`endif

  logic       clk;
  logic       rst_n;
  logic [4:0] id_rs, id_rt, ex_write_reg, me_write_reg;
  logic       id_uses_rt, ex_mem_read, ex_reg_write, me_reg_write, me_pc_src, ext_stall_req;
  logic [1:0] id_jump;
  logic       pc_write, if_id_write, if_id_flush, id_ex_flush, ex_me_flush, jr_fault;
  logic [1:0] pc_sel, ctrl_state;
`ifdef HAZARD_PERF_COUNTERS_EN
  logic [CNT_WIDTH-1:0] stall_count, flush_count;
`endif

  pipeline_hazard_controller #(.CNT_WIDTH(CNT_WIDTH), .JR_WAIT_MAX(JR_WAIT_MAX)) dut (
    .clk(clk), .reset(rst_n),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt), .id_jump(id_jump),
    .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write), .ex_write_reg(ex_write_reg),
    .me_reg_write(me_reg_write), .me_write_reg(me_write_reg),
    .me_pc_src(me_pc_src), .ext_stall_req(ext_stall_req),
    .pc_write(pc_write), .if_id_write(if_id_write), .if_id_flush(if_id_flush),
    .id_ex_flush(id_ex_flush), .ex_me_flush(ex_me_flush), .pc_sel(pc_sel),
    .ctrl_state(ctrl_state), .jr_fault(jr_fault)
`ifdef HAZARD_PERF_COUNTERS_EN
    , .stall_count(stall_count), .flush_count(flush_count)
`endif
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state: what the controller is doing, at rule level
  int m_state;   // 0 run, 1 load-use stall, 2 jr wait, 3 external wait
  int m_wait;
  bit m_fault;
  int m_stalls;
  int m_flushes;

  logic [W-1:0] exp_q[$];
  int total = 0;
  int bad   = 0;

  task automatic idle_inputs();
    id_rs = 0; id_rt = 0; id_uses_rt = 0; id_jump = 0;
    ex_mem_read = 0; ex_reg_write = 0; ex_write_reg = 0;
    me_reg_write = 0; me_write_reg = 0; me_pc_src = 0; ext_stall_req = 0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  // Evaluate the current cycle's inputs against the rule list, push the expectation, advance the model.
  task automatic issue();
    bit pw, iw, f1, f2, f3, lu, jrh, rs_pend, jr_wait_rule;
    logic [1:0] sel;
    int nxt;
    logic [9:0] base;
    logic [W-1:0] e;
    if (!rst_n) begin
      m_state = 0; m_wait = 0; m_fault = 0; m_stalls = 0; m_flushes = 0;
      pw = 0; iw = 0; f1 = 1; f2 = 1; f3 = 1; sel = 2'd0;
    end else begin
      lu = ex_mem_read && ex_write_reg != 0 &&
           (ex_write_reg == id_rs || (id_uses_rt && ex_write_reg == id_rt));
      rs_pend = id_rs != 0 && ((ex_reg_write && ex_write_reg == id_rs) ||
                               (me_reg_write && me_write_reg == id_rs));
      jrh = (id_jump == 2) && rs_pend;
      pw = 1; iw = 1; f1 = 0; f2 = 0; f3 = 0; sel = 2'd0; nxt = 0; jr_wait_rule = 0;
      if (me_pc_src) begin
        sel = 2'd1; f1 = 1; f2 = 1; f3 = 1;
      end else if (ext_stall_req) begin
        pw = 0; iw = 0; nxt = 3;
      end else if (lu) begin
        pw = 0; iw = 0; f2 = 1; nxt = 1;
      end else if (jrh) begin
        pw = 0; iw = 0; f2 = 1; nxt = 2; jr_wait_rule = 1;
      end else if (id_jump == 1) begin
        sel = 2'd2; f1 = 1;
      end else if (id_jump == 2) begin
        sel = 2'd3; f1 = 1;
      end
    end
    base = {pw, iw, f1, f2, f3, sel, 2'(m_state), m_fault};
`ifdef HAZARD_PERF_COUNTERS_EN
    e = {CNT_WIDTH'(m_stalls), CNT_WIDTH'(m_flushes), base};
`else
    e = base;
`endif
    exp_q.push_back(e);
    if (rst_n) begin
      m_state = nxt;
      if (jr_wait_rule) begin
        m_wait++;
        if (m_wait > JR_WAIT_MAX) m_fault = 1;
      end else begin
        m_wait = 0;
      end
      if (!pw && m_stalls < CNT_MAX) m_stalls++;
      if ((f1 || f2 || f3) && m_flushes < CNT_MAX) m_flushes++;
    end
  endtask

  // Scoreboard monitor: sample mid-cycle, away from the active edge
  always @(negedge clk) begin
    logic [W-1:0] act, exp;
    if (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
`ifdef HAZARD_PERF_COUNTERS_EN
      act = {stall_count, flush_count, pc_write, if_id_write, if_id_flush, id_ex_flush,
             ex_me_flush, pc_sel, ctrl_state, jr_fault};
`else
      act = {pc_write, if_id_write, if_id_flush, id_ex_flush, ex_me_flush,
             pc_sel, ctrl_state, jr_fault};
`endif
      total++;
      if (act !== exp) begin
        bad++;
        $display("FAIL outputs t=%0t got=%h want=%h (pw,iw,fl1,fl2,fl3,sel,st,fault)", $time, act, exp);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    m_state = 0; m_wait = 0; m_fault = 0; m_stalls = 0; m_flushes = 0;

    // Reset state
    next_cycle(); rst_n = 0; issue();
    next_cycle(); rst_n = 0; issue();
    next_cycle(); rst_n = 1; issue();

    // Load-use stall for one cycle, then resume
    next_cycle(); ex_mem_read = 1; ex_write_reg = 8; id_rs = 8; issue();
    next_cycle(); issue();
    next_cycle(); issue();
    // Load-use through rt, and rt ignored when not used
    next_cycle(); ex_mem_read = 1; ex_write_reg = 9; id_rt = 9; id_uses_rt = 1; issue();
    next_cycle(); ex_mem_read = 1; ex_write_reg = 9; id_rt = 9; id_uses_rt = 0; issue();
    // Back-to-back load-use
    next_cycle(); ex_mem_read = 1; ex_write_reg = 4; id_rs = 4; issue();
    next_cycle(); ex_mem_read = 1; ex_write_reg = 4; id_rs = 4; issue();
    next_cycle(); issue();

    // Register 0 never stalls
    next_cycle(); ex_mem_read = 1; ex_write_reg = 0; id_rs = 0; issue();
    next_cycle(); id_jump = 2; ex_reg_write = 1; ex_write_reg = 0; id_rs = 0; issue();

    // Branch beats ext stall and load-use
    next_cycle(); me_pc_src = 1; ext_stall_req = 1; ex_mem_read = 1; ex_write_reg = 8; id_rs = 8; issue();
    next_cycle(); issue();

    // j, jr without hazard, reserved encoding
    next_cycle(); id_jump = 1; issue();
    next_cycle(); id_jump = 2; id_rs = 5; issue();
    next_cycle(); id_jump = 3; issue();

    // jr wait: EX match, then ME match, then clear
    next_cycle(); id_jump = 2; id_rs = 31; ex_reg_write = 1; ex_write_reg = 31; issue();
    next_cycle(); id_jump = 2; id_rs = 31; me_reg_write = 1; me_write_reg = 31; issue();
    next_cycle(); id_jump = 2; id_rs = 31; issue();
    next_cycle(); issue();

    // External freeze for two cycles, then release
    next_cycle(); ext_stall_req = 1; issue();
    next_cycle(); ext_stall_req = 1; ex_mem_read = 1; ex_write_reg = 3; id_rs = 3; issue();
    next_cycle(); ex_mem_read = 1; ex_write_reg = 3; id_rs = 3; issue();
    next_cycle(); issue();

    // jr fault: hazard held five cycles
    for (int i = 0; i < 5; i++) begin
      next_cycle(); id_jump = 2; id_rs = 7; me_reg_write = 1; me_write_reg = 7; issue();
    end
    next_cycle(); id_jump = 2; id_rs = 7; issue();
    next_cycle(); issue();
    next_cycle(); issue();

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      next_cycle();
      rst_n         = ($urandom_range(0, 99) != 0);
      id_rs         = 5'($urandom_range(0, 3));
      id_rt         = 5'($urandom_range(0, 3));
      id_uses_rt    = 1'($urandom_range(0, 1));
      id_jump       = 2'($urandom_range(0, 3));
      ex_mem_read   = 1'($urandom_range(0, 2) == 0);
      ex_reg_write  = 1'($urandom_range(0, 1));
      ex_write_reg  = 5'($urandom_range(0, 3));
      me_reg_write  = 1'($urandom_range(0, 1));
      me_write_reg  = 5'($urandom_range(0, 3));
      me_pc_src     = 1'($urandom_range(0, 7) == 0);
      ext_stall_req = 1'($urandom_range(0, 5) == 0);
      issue();
    end

    // Reset asserted in the middle of an external freeze
    next_cycle(); rst_n = 1; issue();
    next_cycle(); ext_stall_req = 1; issue();
    next_cycle(); ext_stall_req = 1; issue();
    next_cycle(); ext_stall_req = 1; rst_n = 0; issue();
    next_cycle(); rst_n = 0; issue();
    next_cycle(); rst_n = 1; issue();
    next_cycle(); issue();

    @(negedge clk);
    #1;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_controller.md
Name: pipeline_hazard_controller

Overview:
Central stall/flush/PC-select sequencer for the 5-stage MIPS pipeline (IF, ID, EX, ME, WB).
- Detects load-use hazards and jr source hazards.
- Resolves taken branches (ME stage), j/jal (ID stage) and jr (ID stage).
- Honours an external freeze request, e.g. multi-cycle data memory.
- Drives PC write-enable, IF/ID write-enable, per-register flushes and the next-PC mux select.

Parameters:
CNT_WIDTH, 16, width of the saturating performance counters.
JR_WAIT_MAX, 3, maximum consecutive JR_WAIT cycles before the fault flag sets.

Ports:
clk  input  1  pipeline clock, rising edge
reset  input  1  asynchronous, active-low reset
id_rs  input  5  rs field of instruction in ID
id_rt  input  5  rt field of instruction in ID
id_uses_rt  input  1  ID instruction reads rt as ALU/store source
id_jump  input  2  ID jump decode: 00 none, 01 j/jal, 10 jr, 11 reserved (treated as 00)
ex_mem_read  input  1  instruction in EX is a load
ex_reg_write  input  1  EX instruction writes a register
ex_write_reg  input  5  EX destination register
me_reg_write  input  1  ME instruction writes a register
me_write_reg  input  5  ME destination register
me_pc_src  input  1  branch taken, resolved in ME
ext_stall_req  input  1  external freeze request
pc_write  output  1  PC register load enable
if_id_write  output  1  IF/ID register load enable
if_id_flush  output  1  IF/ID clear to NOP
id_ex_flush  output  1  ID/EX clear to bubble (all control bits 0)
ex_me_flush  output  1  EX/ME clear to bubble
pc_sel  output  2  00 PC+4, 01 branch target, 10 jump target, 11 jr (rs value)
ctrl_state  output  2  current FSM state encoding
jr_fault  output  1  sticky: jr waited more than JR_WAIT_MAX cycles

Behaviour:
- Register $0 never causes a hazard. Any match involving register 0 is ignored.
- Control outputs are combinational from current state and inputs, so they act in the same cycle. State and flags are registered.
- States: RUN=00, LU_STALL=01, JR_WAIT=10, EXT_WAIT=11.
- Per-cycle priority, highest first:
  1. me_pc_src=1:
     - pc_sel=01, pc_write=1, if_id_write=1.
     - if_id_flush=id_ex_flush=ex_me_flush=1.
     - Next state RUN from any state; it aborts any stall or wait.
  2. ext_stall_req=1:
     - pc_write=0, if_id_write=0, no flushes, pc_sel=00.
     - Next state EXT_WAIT.
     - After the request drops, the FSM returns to RUN and re-evaluates hazards that cycle.
  3. Load-use: ex_mem_read & (ex_write_reg==id_rs | (id_uses_rt & ex_write_reg==id_rt)), non-zero register.
     - pc_write=0, if_id_write=0, id_ex_flush=1.
     - Next state LU_STALL.
  4. jr hazard: id_jump=10 and rs pending, i.e. (ex_reg_write & ex_write_reg==id_rs) | (me_reg_write & me_write_reg==id_rs).
     - pc_write=0, if_id_write=0, id_ex_flush=1.
     - Next state JR_WAIT; the wait counter increments.
  5. id_jump=01:
     - pc_sel=10, pc_write=1, if_id_flush=1.
  6. id_jump=10 with no hazard:
     - pc_sel=11, pc_write=1, if_id_flush=1.
  7. Otherwise: pc_write=1, if_id_write=1, no flush, pc_sel=00.
- LU_STALL:
  - Lasts exactly one cycle. The hazard is then covered by forwarding.
  - Next cycle re-evaluates from RUN rules.
  - Back-to-back load-use is allowed.
- JR_WAIT:
  - Repeats rule 4 until rs is no longer pending; the cycle rs clears, rule 6 fires.
  - The wait counter clears on leaving JR_WAIT.
  - When the counter exceeds JR_WAIT_MAX, jr_fault sets and holds until reset. Stalling continues regardless.
- Reset asserted (reset=0):
  - state=RUN, jr_fault=0, wait counter=0, counters=0.
  - pc_write=0, if_id_write=0, all flushes=1, pc_sel=00.
- Reset released: first edge operates normally.

Optional Feature:
HAZARD_PERF_COUNTERS_EN
- Defined: adds outputs stall_count[CNT_WIDTH-1:0] and flush_count[CNT_WIDTH-1:0].
  - stall_count increments on each cycle with pc_write=0 (reset excluded).
  - flush_count increments per cycle with any flush asserted.
  - Both saturate at all-ones and clear on reset.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Load-use: ex_mem_read=1, ex_write_reg=8, id_rs=8 → one cycle: pc_write=0, if_id_write=0, id_ex_flush=1, ctrl_state=01. Next cycle (ex_mem_read=0) → pc_write=1, ctrl_state=00.
- Register 0: ex_mem_read=1, ex_write_reg=0, id_rs=0 → no stall, pc_write=1.
- Branch over stall: me_pc_src=1 with a simultaneous load-use and ext_stall_req=1 → pc_sel=01, all three flushes=1, pc_write=1, next state RUN.
- jr wait: id_jump=10, id_rs=31, ex_reg_write=1, ex_write_reg=31 → stall. Next cycle only the ME match remains → stall. Next cycle clear → pc_sel=11, if_id_flush=1. jr_fault stays 0.
- jr fault: hold jr hazard 5 cycles with JR_WAIT_MAX=3 → jr_fault=1 from the 5th stall cycle. It stays 1 after the hazard clears, until reset=0.
- Reset mid-stall: ext_stall_req=1 for 2 cycles, then reset=0 asynchronously → outputs immediately show pc_write=0 and flushes=1. After release, state=00 and (with HAZARD_PERF_COUNTERS_EN) stall_count=0.
